// File: rtl/config_chain_loader_if.sv
`default_nettype none
// ============================================================================
// Module   : config_chain_loader_if
// Brief    : Bitstream word handshake (data/valid/ready) into the chain loader.
// Revision : 1.0 - initial release
// ============================================================================
interface config_chain_loader_if #(
  parameter int WORD_WIDTH = 8
);
  logic [WORD_WIDTH-1:0] s_data;
  logic                  s_valid;
  logic                  s_ready;

  modport master (output s_data, output s_valid, input s_ready);
  modport slave  (input s_data, input s_valid, output s_ready);
endinterface
`default_nettype wire

// File: rtl/config_chain_loader.sv
`default_nettype none
// ============================================================================
// Module   : config_chain_loader
// Brief    : Serialises bitstream words LSB-first onto the configuration chain
//            head; optional CRC-8 check via CONFIG_CHAIN_LOADER_CRC_EN.
// Revision : 1.0 - initial release
// ============================================================================
module config_chain_loader #(
  parameter int WORD_WIDTH   = 8,
  parameter int CHAIN_LENGTH = 20,
  parameter int CNT_WIDTH    = $clog2(CHAIN_LENGTH + 1)
) (
  input  wire logic             clk,
  input  wire logic             reset,
  input  wire logic             start,
  config_chain_loader_if.slave  s_if,
  output logic                  chain_head,
  output logic                  chain_shift_en,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  localparam int                 c_bcnt_w    = $clog2(WORD_WIDTH + 1);
  localparam logic [c_bcnt_w-1:0]  c_word_len  = c_bcnt_w'(WORD_WIDTH);
  localparam logic [c_bcnt_w-1:0]  c_bcnt_one  = c_bcnt_w'(1);
  localparam logic [CNT_WIDTH-1:0] c_chain_len = CNT_WIDTH'(CHAIN_LENGTH);
  localparam logic [CNT_WIDTH-1:0] c_total_one = CNT_WIDTH'(1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_SHIFT = 3'd2,
`ifdef CONFIG_CHAIN_LOADER_CRC_EN
    ST_CHECK = 3'd3,
`endif
    ST_DONE  = 3'd4
  } state_t;

  state_t                r_state, w_state_nx;
  logic [WORD_WIDTH-1:0] r_shift, w_shift_nx;
  logic [c_bcnt_w-1:0]   r_bcnt, w_bcnt_nx, w_bcnt_inc;
  logic [CNT_WIDTH-1:0]  r_total, w_total_nx, w_total_inc;
  logic                  r_head, w_head_nx;
  logic                  r_shift_en, w_shift_en_nx;
  logic                  r_ready, w_ready_nx;
  logic                  r_busy, w_busy_nx;
  logic                  r_done, w_done_nx;

`ifdef CONFIG_CHAIN_LOADER_CRC_EN
  logic [7:0]            r_crc, w_crc_nx;
  logic                  r_error, w_error_nx;

  // MSB-first CRC-8, polynomial x^8 + x^2 + x + 1
  function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic bit_in);
    logic fb;
    fb        = crc[7] ^ bit_in;
    crc8_step = {crc[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
  endfunction
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx    = r_state;
    w_shift_nx    = r_shift;
    w_bcnt_nx     = r_bcnt;
    w_total_nx    = r_total;
    w_head_nx     = 1'b0;
    w_shift_en_nx = 1'b0;
    w_ready_nx    = 1'b0;
    w_busy_nx     = r_busy;
    w_done_nx     = r_done;
    w_bcnt_inc    = r_bcnt + c_bcnt_one;
    w_total_inc   = r_total + c_total_one;
`ifdef CONFIG_CHAIN_LOADER_CRC_EN
    w_crc_nx      = r_crc;
    w_error_nx    = r_error;
`endif
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          w_state_nx = ST_LOAD;
          w_total_nx = '0;
          w_bcnt_nx  = '0;
          w_ready_nx = 1'b1;
          w_busy_nx  = 1'b1;
          w_done_nx  = 1'b0;
`ifdef CONFIG_CHAIN_LOADER_CRC_EN
          w_crc_nx   = 8'h00;
          w_error_nx = 1'b0;
`endif
        end
      end
      ST_LOAD: begin
        if (s_if.s_valid) begin
          // Bit 0 goes straight to the head flop; the rest queue in r_shift
          w_state_nx    = ST_SHIFT;
          w_head_nx     = s_if.s_data[0];
          w_shift_nx    = s_if.s_data >> 1;
          w_shift_en_nx = 1'b1;
          w_bcnt_nx     = '0;
        end else begin
          w_ready_nx = 1'b1;
        end
      end
      ST_SHIFT: begin
        w_bcnt_nx  = w_bcnt_inc;
        w_total_nx = w_total_inc;
`ifdef CONFIG_CHAIN_LOADER_CRC_EN
        w_crc_nx   = crc8_step(r_crc, r_head);
`endif
        if (w_total_inc == c_chain_len) begin
`ifdef CONFIG_CHAIN_LOADER_CRC_EN
          w_state_nx = ST_CHECK;
          w_ready_nx = 1'b1;
`else
          w_state_nx = ST_DONE;
          w_busy_nx  = 1'b0;
          w_done_nx  = 1'b1;
`endif
        end else if (w_bcnt_inc == c_word_len) begin
          w_state_nx = ST_LOAD;
          w_ready_nx = 1'b1;
        end else begin
          w_head_nx     = r_shift[0];
          w_shift_nx    = r_shift >> 1;
          w_shift_en_nx = 1'b1;
        end
      end
`ifdef CONFIG_CHAIN_LOADER_CRC_EN
      ST_CHECK: begin
        if (s_if.s_valid) begin
          w_error_nx = (s_if.s_data[7:0] != r_crc);
          w_state_nx = ST_DONE;
          w_busy_nx  = 1'b0;
          w_done_nx  = 1'b1;
        end else begin
          w_ready_nx = 1'b1;
        end
      end
`endif
      default: w_state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_shift    <= '0;
      r_bcnt     <= '0;
      r_total    <= '0;
      r_head     <= 1'b0;
      r_shift_en <= 1'b0;
      r_ready    <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
`ifdef CONFIG_CHAIN_LOADER_CRC_EN
      r_crc      <= 8'h00;
      r_error    <= 1'b0;
`endif
    end else begin
      r_shift    <= w_shift_nx;
      r_bcnt     <= w_bcnt_nx;
      r_total    <= w_total_nx;
      r_head     <= w_head_nx;
      r_shift_en <= w_shift_en_nx;
      r_ready    <= w_ready_nx;
      r_busy     <= w_busy_nx;
      r_done     <= w_done_nx;
`ifdef CONFIG_CHAIN_LOADER_CRC_EN
      r_crc      <= w_crc_nx;
      r_error    <= w_error_nx;
`endif
    end
  end

  assign s_if.s_ready   = r_ready;
  assign chain_head     = r_head;
  assign chain_shift_en = r_shift_en;
  assign busy           = r_busy;
  assign done           = r_done;
`ifdef CONFIG_CHAIN_LOADER_CRC_EN
  assign error          = r_error;
`else
  assign error          = 1'b0;
`endif

endmodule
`default_nettype wire

// File: doc/config_chain_loader.md
Name: config_chain_loader

Overview:
- Upstream feeder for the fabric configuration chain, i.e. the serial chain of DFF cells wired D-to-Q.
- Accepts bitstream words from the programming interface over a valid/ready handshake.
- Serializes each word LSB-first onto the chain head, with a per-bit shift enable that drives the chain's clock-gate enable.
- Counts bits so that exactly CHAIN_LENGTH bits are shifted per programming run, then signals completion.

Parameters:
- WORD_WIDTH, 8, bits per input bitstream word (>=2).
- CHAIN_LENGTH, 20, total configuration DFFs in the chain (>=1).
- CNT_WIDTH, $clog2(CHAIN_LENGTH+1), width of the total-bit counter (derived; do not override).

Ports:
- clk  input  1  fabric programming clock.
- reset  input  1  asynchronous active-low reset; 0 = reset asserted.
- start  input  1  one-cycle pulse that begins a programming run.
- s_data  input  WORD_WIDTH  bitstream word.
- s_valid  input  1  s_data valid.
- s_ready  output  1  loader can accept a word.
- chain_head  output  1  serial bit to the D input of the first chain DFF.
- chain_shift_en  output  1  high in each cycle the chain must capture chain_head.
- busy  output  1  programming run in progress.
- done  output  1  run complete; sticky until the next start.
- error  output  1  integrity failure (optional feature only).

Behaviour:
- Clock and reset: single clock domain. Reset is asynchronous and active-low.
- While reset=0, all state and outputs clear: state=IDLE, s_ready=0, chain_head=0, chain_shift_en=0, busy=0, done=0, error=0, counters=0.
- Reset mid-run abandons the run with no resume. The chain contents are then undefined; the fabric DFFs are reset by the same net.
- Outputs: all are registered; no combinational input-to-output path.
- States: IDLE, LOAD, SHIFT, CHECK (optional feature only), DONE.
- IDLE: start=1 -> LOAD on the next cycle; busy=1 and the bit counter clears.
- LOAD:
  - s_ready=1.
  - s_valid=1 at a clock edge -> word captured into the shift register -> SHIFT on the next cycle; s_ready drops.
  - s_valid=0 -> remain in LOAD, chain_shift_en=0, no bit counted.
- SHIFT:
  - Each cycle: chain_head = shift_reg[0] and chain_shift_en=1; the shift register shifts right; the word-bit counter and the total counter each increment by 1.
  - Leave SHIFT after WORD_WIDTH bits, or as soon as the total reaches CHAIN_LENGTH, whichever comes first.
  - Unshifted upper bits of the final word are discarded.
  - Total < CHAIN_LENGTH -> back to LOAD.
  - Total = CHAIN_LENGTH -> DONE (or CHECK if the optional feature is enabled).
- Per-word timing: a word costs 1 handshake cycle plus up to WORD_WIDTH shift cycles. There is no prefetch: s_ready is 0 throughout SHIFT.
- DONE: busy=0, done=1, chain_shift_en=0, chain_head=0. start=1 -> LOAD; done clears and the counter resets.
- start: ignored in LOAD, SHIFT and CHECK.
- Extra words: words presented after the final bit are not accepted (s_ready=0).
- Counters: the total counter never exceeds CHAIN_LENGTH and never wraps.
- Boundary: CHAIN_LENGTH < WORD_WIDTH -> a single word, partially shifted.
- Boundary: CHAIN_LENGTH an exact multiple of WORD_WIDTH -> no discarded bits.

Optional Feature:
- Macro: CONFIG_CHAIN_LOADER_CRC_EN.
- Defined:
  - CRC-8 (polynomial 0x07, init 0x00, MSB-first register) updates with every bit driven on chain_head while chain_shift_en=1.
  - After the final bit the FSM enters CHECK, with s_ready=1 and busy=1.
  - The next accepted word's bits [7:0] are compared with the CRC. Mismatch -> error=1, sticky until the next start. Either way the FSM then moves to DONE.
  - WORD_WIDTH must be >= 8 when this feature is enabled.
- Undefined: no CRC logic and no CHECK state; error is tied 0.

Test Plan:
- Nominal run (WORD_WIDTH=8, CHAIN_LENGTH=20): start, then words 0xA5, 0x3C, 0x0F with s_valid held high.
  - chain_head in shift-enabled cycles: 1,0,1,0,0,1,0,1, 0,0,1,1,1,1,0,0, 1,1,1,1.
  - Exactly 20 chain_shift_en cycles; done=1 on the cycle after the 20th bit; the upper nibble of 0x0F is discarded.
- Backpressure: s_valid=0 for 5 cycles in LOAD before the second word -> s_ready=1 throughout, chain_shift_en=0, total count frozen at 8. The run then finishes identically to the nominal case.
- start while busy: pulse start during SHIFT of word 2 -> no effect; the bit sequence and done timing match the nominal case.
- Reset mid-run: drive reset=0 during word 2 SHIFT -> all outputs 0 immediately (asynchronously). After release the FSM is in IDLE, and a fresh start performs a complete nominal run.
- Restart from DONE: start in DONE -> done=0 next cycle, busy=1, s_ready=1; a second 20-bit run completes.
- CRC (macro defined): after the nominal run, send a word equal to the computed CRC -> error=0, done=1. Repeat with the CRC value XOR 0x01 -> error=1, done=1.
